// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_pkg
//  Description : Shared constants for the general-purpose register file:
//                default widths, reset values of $gp/$sp and the
//                architectural register indices used by the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpr_pkg;

    // Default geometry of the register file
    localparam int DATA_W_DFLT = 32;
    localparam int ADDR_W_DFLT = 5;

    // Reset values of the global and stack pointers
    localparam logic [31:0] GP_RESET_DFLT = 32'h0000_1800;
    localparam logic [31:0] SP_RESET_DFLT = 32'h0000_2ffc;

    // Architectural register indices
    localparam int REG_ZERO = 0;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage : gpr_pkg
`default_nettype wire

// File: rtl/gpr_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_read_port
//  Description : One operand read port of the register file. Forces index 0
//                to zero, optionally forwards a same-cycle write into the
//                operand (write-through), and holds the result in an operand
//                latch that only updates when ld_i is high.
//  Config      : GPR_BYPASS_EN - when defined, a committed write to the
//                register being loaded is forwarded into the latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_read_port
    import gpr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic              ld_i,       // load the operand latch this cycle
    input  logic [ADDR_W-1:0] raddr_i,    // register index being read
    input  logic [DATA_W-1:0] rdata_i,    // raw array contents at raddr_i
`ifdef GPR_BYPASS_EN
    input  logic              wr_en_i,    // a non-$0 write commits this cycle
    input  logic [ADDR_W-1:0] waddr_i,    // index of that write
    input  logic [DATA_W-1:0] wdata_i,    // data of that write
`endif
    output logic [DATA_W-1:0] latch_o
);

    logic              w_is_zero;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_sel_val;
    logic [DATA_W-1:0] latch_d;
    logic [DATA_W-1:0] latch_q;

    assign w_is_zero = (raddr_i == ADDR_W'(REG_ZERO));

    // $0 is hardwired to zero whatever the array happens to hold
    always_comb begin
        w_rd_val = rdata_i;
        if (w_is_zero) begin
            w_rd_val = '0;
        end
    end

`ifdef GPR_BYPASS_EN
    logic w_hit;

    // A committed write to the index being read wins over the stored value;
    // $0 is excluded explicitly so it can never be forwarded
    assign w_hit = wr_en_i && !w_is_zero && (waddr_i == raddr_i);

    // Select the forwarded write data on a hit, else the stored value
    always_comb begin
        w_sel_val = w_rd_val;
        if (w_hit) begin
            w_sel_val = wdata_i;
        end
    end
`else
    // Without forwarding the latch always sees the pre-write value
    always_comb begin
        w_sel_val = w_rd_val;
    end
`endif

    // Operand latch next state: load on ld_i, otherwise hold
    always_comb begin
        latch_d = latch_q;
        if (ld_i) begin
            latch_d = w_sel_val;
        end
    end

    // Operand latch register, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign latch_o = latch_q;

endmodule : gpr_read_port
`default_nettype wire

// File: rtl/gpr_file.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_file
//  Description : Multicycle-CPU general-purpose register file. 2**ADDR_W
//                registers of DATA_W bits, one write per cycle, two read
//                ports captured into A/B operand latches during ID. $0 reads
//                as zero; $gp and $sp leave reset at fixed non-zero values.
//                wr_cnt counts committed (non-$0) writes and wraps.
//  Config      : GPR_BYPASS_EN - when defined, a write and an operand load of
//                the same register in one cycle forward the new data into
//                the latch; otherwise the latch captures the old data.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_file
    import gpr_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DFLT,
    parameter int                ADDR_W   = ADDR_W_DFLT,
    parameter logic [DATA_W-1:0] GP_RESET = DATA_W'(GP_RESET_DFLT),
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DFLT)
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic              we,         // GPRWr from the control FSM
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              ld_ab,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [15:0]       wr_cnt
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [15:0]       wr_cnt_d;
    logic [15:0]       wr_cnt_q;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_raw_a;
    logic [DATA_W-1:0] w_raw_b;

    // Reset value of each register: $gp and $sp are preset, the rest clear
    function automatic logic [DATA_W-1:0] reset_value(input int idx);
        if (idx == REG_GP) begin
            return GP_RESET;
        end else if (idx == REG_SP) begin
            return SP_RESET;
        end
        return '0;
    endfunction

    // A write only commits when enabled and not aimed at $0
    assign w_wr_en = we && (waddr != ADDR_W'(REG_ZERO));

    // Register array: preset on reset, one indexed write per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= reset_value(i);
            end
        end else if (w_wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Committed-write counter next state, wrapping at 2**16
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (w_wr_en) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // Committed-write counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Raw array lookups; the read ports take care of $0
    assign w_raw_a = regs_q[raddr_a];
    assign w_raw_b = regs_q[raddr_b];

    gpr_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (ld_ab),
        .raddr_i (raddr_a),
        .rdata_i (w_raw_a),
`ifdef GPR_BYPASS_EN
        .wr_en_i (w_wr_en),
        .waddr_i (waddr),
        .wdata_i (wdata),
`endif
        .latch_o (a_out)
    );

    gpr_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (ld_ab),
        .raddr_i (raddr_b),
        .rdata_i (w_raw_b),
`ifdef GPR_BYPASS_EN
        .wr_en_i (w_wr_en),
        .waddr_i (waddr),
        .wdata_i (wdata),
`endif
        .latch_o (b_out)
    );

    assign wr_cnt = wr_cnt_q;

endmodule : gpr_file
`default_nettype wire
